// File: rtl/yolo_bram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | yolo_bram_pkg : default widths and FSM encoding for bram_stream_reader|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package yolo_bram_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 10;

   typedef logic [1:0] bram_state_t;

   localparam bram_state_t ST_IDLE  = 2'd0;
   localparam bram_state_t ST_RUN   = 2'd1;
   localparam bram_state_t ST_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bram_rd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_rd_fifo : synchronous skid FIFO, head word visible on dout      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module bram_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clka,
   input  logic                     rstb,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clka) begin
      if (rstb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clka) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_stream_reader : burst reader from a BRAM port into a stream     |
// | Option: BRAM_RD_STALL_CNT_EN enables the backpressure stall counter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module bram_stream_reader #(
   parameter int DATA_W     = yolo_bram_pkg::DATA_W,
   parameter int ADDR_W     = yolo_bram_pkg::ADDR_W,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clka,
   input  logic              rstb,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_en,
   output logic              ram_regce,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic [31:0]       stall_cnt
);

   import yolo_bram_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int LVL_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

   bram_state_t         state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     rd_left_q, rd_left_d;
   logic [ADDR_W:0]     beats_left_q, beats_left_d;
   logic [RD_LATENCY-1:0] sr_q, sr_d;
   logic                done_q, done_d;

   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic                pop;
   logic                issue;
   logic [LVL_W-1:0]    inflight;
   logic [LVL_W-1:0]    level;

   bram_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clka  (clka),
      .rstb  (rstb),
      .push  (sr_q[RD_LATENCY-1]),
      .din   (ram_dout),
      .pop   (pop),
      .dout  (m_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + LVL_W'(sr_q[i]);
      end
   end

   // Buffered plus in-flight words after this cycle's pop must leave room for one more read.
   assign level     = LVL_W'(fifo_count) + inflight - LVL_W'(pop);
   assign issue     = !rstb && (state_q == ST_RUN) && (level < LVL_W'(FIFO_DEPTH))
                      && (!fifo_full || pop);

   assign m_valid   = !rstb && !fifo_empty;
   assign pop       = m_valid && m_ready;
   assign m_last    = m_valid && (beats_left_q == (ADDR_W+1)'(1));
   assign ram_en    = issue;
   assign ram_addr  = addr_q;
   assign ram_regce = 1'b1;
   assign busy      = !rstb && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
   assign done      = !rstb && done_q;

   if (RD_LATENCY == 1) begin : g_sr_one
      assign sr_d = issue;
   end else begin : g_sr_shift
      assign sr_d = {sr_q[RD_LATENCY-2:0], issue};
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rd_left_d    = rd_left_q;
      beats_left_d = beats_left_q;
      done_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  addr_d       = base_addr;
                  rd_left_d    = length;
                  beats_left_d = length;
                  state_d      = ST_RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (issue) begin
               addr_d    = addr_q + 1'b1;
               rd_left_d = rd_left_q - 1'b1;
               if (rd_left_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && m_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) beats_left_d = beats_left_d - 1'b1;
   end

   always_ff @(posedge clka) begin
      if (rstb) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         rd_left_q    <= '0;
         beats_left_q <= '0;
         sr_q         <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rd_left_q    <= rd_left_d;
         beats_left_q <= beats_left_d;
         sr_q         <= sr_d;
         done_q       <= done_d;
      end
   end

`ifdef BRAM_RD_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clka) begin
      if (rstb) begin
         stall_q <= '0;
      end else if ((state_q == ST_IDLE) && start) begin
         stall_q <= '0;
      end else if (m_valid && !m_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bram_stream_reader : bench with BRAM model and burst reference    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_bram_stream_reader;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 10;
   localparam int RD_LATENCY = 2;
   localparam int FIFO_DEPTH = 4;

   logic              clka = 1'b0;
   logic              rstb;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_en;
   logic              ram_regce;
   logic [DATA_W-1:0] ram_dout;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              busy;
   logic              done;
   logic [31:0]       stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clka = ~clka;

   bram_stream_reader #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .RD_LATENCY (RD_LATENCY),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clka      (clka),
      .rstb      (rstb),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .ram_addr  (ram_addr),
      .ram_en    (ram_en),
      .ram_regce (ram_regce),
      .ram_dout  (ram_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done),
      .stall_cnt (stall_cnt)
   );

   // Behavioural BRAM: enable-gated read register followed by the output register.
   logic [DATA_W-1:0] mem  [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] pipe [0:RD_LATENCY-1];

   always @(posedge clka) begin
      if (ram_en) pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LATENCY; i++) begin
         if (ram_regce) pipe[i] <= pipe[i-1];
      end
   end
   assign ram_dout = pipe[RD_LATENCY-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycle 0 is the start cycle; the model predicts addresses, data order, beat
   // positions and timing from the burst parameters alone.
   task automatic run_burst(input string nm, input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                            input int hold, input bit rnd_ready, input int restart_at);
      int issues = 0, beats = 0, first_valid = -1, first_issue = -1, last_issue = -1;
      int last_hs = -1, dones = 0, done_c = -1, fill_at_hold = -1;
      int bad_addr = 0, bad_busy = 0, bad_last = 0, over = 0;
      int stall_exp;
      bit busy_exp;
      for (int c = 0; c < 400; c++) begin
         start     = (c == 0) || (c == restart_at);
         base_addr = (c == 0) ? base : base + 10'h155;
         length    = (c == 0) ? len : 11'd3;
         m_ready   = (c < hold) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         #2;
         if (ram_en) begin
            if (ram_addr !== ADDR_W'(base + issues)) bad_addr++;
            if (first_issue < 0) first_issue = c;
            last_issue = c;
            issues++;
         end
         busy_exp = (len != 0) && (c >= 1) && (last_hs < 0);
         if (busy !== busy_exp) bad_busy++;
         if (m_valid) begin
            if (first_valid < 0) first_valid = c;
            chk({nm, " data"}, 64'(m_data), 64'(mem[ADDR_W'(base + beats)]));
            if (m_last !== (beats == int'(len) - 1)) bad_last++;
            if (m_ready) begin
               beats++;
               if (beats == int'(len)) last_hs = c;
            end
         end else if (m_last !== 1'b0) begin
            bad_last++;
         end
         if (issues - beats > FIFO_DEPTH) over++;
         if (c == hold - 1) fill_at_hold = issues;
         if (done === 1'b1) begin
            dones++;
            done_c = c;
         end
         @(posedge clka); #1;
         if (done_c >= 0 && c >= done_c + 3) break;
      end
      start   = 1'b0;
      m_ready = 1'b1;
      chk({nm, " issues"},   64'(issues),   64'(len));
      chk({nm, " beats"},    64'(beats),    64'(len));
      chk({nm, " addr"},     64'(bad_addr), 64'd0);
      chk({nm, " busy"},     64'(bad_busy), 64'd0);
      chk({nm, " last"},     64'(bad_last), 64'd0);
      chk({nm, " overflow"}, 64'(over),     64'd0);
      chk({nm, " dones"},    64'(dones),    64'd1);
      chk({nm, " done_cyc"}, 64'(done_c),   (len == 0) ? 64'd1 : 64'(last_hs + 1));
      if (len == 0) begin
         chk({nm, " no_read"},  64'(first_issue), 64'(-1));
         chk({nm, " no_valid"}, 64'(first_valid), 64'(-1));
      end else begin
         chk({nm, " first_issue"}, 64'(first_issue), 64'd1);
         chk({nm, " first_valid"}, 64'(first_valid), 64'(RD_LATENCY + 2));
      end
      if (len != 0 && hold == 0 && !rnd_ready) begin
         chk({nm, " last_issue"}, 64'(last_issue), 64'(len));
         chk({nm, " last_beat"},  64'(last_hs),    64'(int'(len) + RD_LATENCY + 1));
      end
      if (hold >= RD_LATENCY + FIFO_DEPTH + 2 && int'(len) > FIFO_DEPTH)
         chk({nm, " fill"}, 64'(fill_at_hold), 64'(FIFO_DEPTH));
      if (!rnd_ready) begin
`ifdef BRAM_RD_STALL_CNT_EN
         stall_exp = (len != 0 && hold > RD_LATENCY + 2) ? hold - (RD_LATENCY + 2) : 0;
`else
         stall_exp = 0;
`endif
         chk({nm, " stall_cnt"}, 64'(stall_cnt), 64'(stall_exp));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] = '0;
      rstb = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;

      // Reset state
      @(posedge clka); #1;
      @(posedge clka); #1;
      chk("rst ram_en",  64'(ram_en),    64'd0);
      chk("rst m_valid", 64'(m_valid),   64'd0);
      chk("rst m_last",  64'(m_last),    64'd0);
      chk("rst busy",    64'(busy),      64'd0);
      chk("rst done",    64'(done),      64'd0);
      chk("rst regce",   64'(ram_regce), 64'd1);
      chk("rst addr",    64'(ram_addr),  64'd0);
      rstb = 1'b0;
      @(posedge clka); #1;
      chk("idle stall", 64'(stall_cnt), 64'd0);

      run_burst("s1 wrap",    10'h3FC, 11'd8, 0, 1'b0, -1);
      run_burst("s2 backpr",  ADDR_W'($urandom), 11'd16, 12, 1'b0, -1);
      run_burst("s3 len0",    ADDR_W'($urandom), 11'd0, 0, 1'b0, -1);
      run_burst("s4 restart", ADDR_W'($urandom), 11'd8, 0, 1'b0, 3);

      // Reset at the third beat of an 8-word burst
      base_addr = 10'h120; length = 11'd8; start = 1'b1; m_ready = 1'b1;
      @(posedge clka); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clka); #1; end
      chk("s5 beat3 valid", 64'(m_valid), 64'd1);
      rstb = 1'b1;
      #2;
      chk("s5 rst outs", 64'({ram_en, m_valid, m_last, busy, done}), 64'd0);
      chk("s5 rst regce", 64'(ram_regce), 64'd1);
      @(posedge clka); #1;
      rstb = 1'b0;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         #2;
         if ({ram_en, m_valid, m_last, busy, done} !== 5'b0) bad++;
         @(posedge clka); #1;
      end
      chk("s5 quiet", 64'(bad), 64'd0);
      run_burst("s5 after", ADDR_W'($urandom), 11'd5, 0, 1'b0, -1);

      run_burst("s6 stall", ADDR_W'($urandom), 11'd4, 9, 1'b0, -1);

      for (int r = 0; r < 6; r++) begin
         run_burst($sformatf("rnd%0d", r), ADDR_W'($urandom),
                   11'($urandom_range(1, 24)), 0, 1'b1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
